// File: rtl/mem_access_ctrl.sv
// Memory access controller: arbitrates instruction fetch and data requests onto
// one shared single-port memory, with read-merge-write for byte stores.
module mem_access_ctrl #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_is_byte,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MERGE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [2:0] LIMIT_C = 3'(STARVE_LIMIT);

    state_t      state_r;
    logic [2:0]  starve_cnt_r;
    logic [31:0] hold_word_r;
    logic [31:0] addr_r;
    logic [7:0]  wbyte_r;
    logic [31:0] if_rdata_r;
    logic [31:0] d_rdata_r;
    logic        if_ready_r;
    logic        d_ready_r;

    logic        grant_d_s;
    logic        grant_f_s;
    logic [31:0] mem_addr_s;
    logic [31:0] mem_wdata_s;
    logic        mem_we_s;

    function automatic logic [31:0] load_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        return {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] merge_byte(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [7:0] b);
        logic [31:0] r;
        r = word;
        case (lane)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            2'd3:    r[31:24] = b;
            default: r        = word;
        endcase
        return r;
    endfunction

    // Arbitration: data wins unless fetch has been starved STARVE_LIMIT times.
    always_comb begin
        grant_d_s = 1'b0;
        grant_f_s = 1'b0;
        if (state_r == IDLE) begin
            grant_d_s = d_req && !(if_req && (starve_cnt_r == LIMIT_C));
            grant_f_s = if_req && !grant_d_s;
        end else begin
            grant_d_s = 1'b0;
            grant_f_s = 1'b0;
        end
    end

    // Memory port drive; grant-cycle accesses must reach memory in the same cycle.
    always_comb begin
        mem_addr_s  = {addr_r[31:2], 2'b00};
        mem_wdata_s = 32'h0000_0000;
        mem_we_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_d_s) begin
                    mem_addr_s = {d_addr[31:2], 2'b00};
                    if (d_we && !d_is_byte) begin
                        mem_we_s    = 1'b1;
                        mem_wdata_s = d_wdata;
                    end else begin
                        mem_we_s    = 1'b0;
                    end
                end else if (grant_f_s) begin
                    mem_addr_s = {if_addr[31:2], 2'b00};
                end else begin
                    mem_addr_s = {addr_r[31:2], 2'b00};
                end
            end
            MERGE: begin
                mem_we_s    = 1'b1;
                mem_wdata_s = merge_byte(hold_word_r, addr_r[1:0], wbyte_r);
            end
            RESP: begin
                mem_we_s = 1'b0;
            end
            default: begin
                mem_we_s = 1'b0;
            end
        endcase
    end

    // Reset gates the write strobe so an aborted access can never touch memory.
    assign mem_we    = mem_we_s & reset_n;
    assign mem_addr  = mem_addr_s;
    assign mem_wdata = mem_wdata_s;
    assign if_rdata  = if_rdata_r;
    assign d_rdata   = d_rdata_r;
    assign if_ready  = if_ready_r;
    assign d_ready   = d_ready_r;

    // Access FSM with starvation counter and registered results/ready pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            starve_cnt_r <= 3'd0;
            hold_word_r  <= 32'h0000_0000;
            addr_r       <= 32'h0000_0000;
            wbyte_r      <= 8'h00;
            if_rdata_r   <= 32'h0000_0000;
            d_rdata_r    <= 32'h0000_0000;
            if_ready_r   <= 1'b0;
            d_ready_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if_ready_r <= 1'b0;
                    d_ready_r  <= 1'b0;
                    if (grant_d_s) begin
                        addr_r       <= d_addr;
                        wbyte_r      <= d_wdata[7:0];
                        starve_cnt_r <= if_req ? (starve_cnt_r + 3'd1) : 3'd0;
                        if (!d_we) begin
                            d_rdata_r <= d_is_byte ? load_byte(mem_rdata, d_addr[1:0]) : mem_rdata;
                            d_ready_r <= 1'b1;
                            state_r   <= RESP;
                        end else if (d_is_byte) begin
                            hold_word_r <= mem_rdata;
                            state_r     <= MERGE;
                        end else begin
                            d_ready_r <= 1'b1;
                            state_r   <= RESP;
                        end
                    end else if (grant_f_s) begin
                        addr_r       <= if_addr;
                        if_rdata_r   <= mem_rdata;
                        if_ready_r   <= 1'b1;
                        starve_cnt_r <= 3'd0;
                        state_r      <= RESP;
                    end else begin
                        starve_cnt_r <= 3'd0;
                        state_r      <= IDLE;
                    end
                end
                MERGE: begin
                    d_ready_r <= 1'b1;
                    state_r   <= RESP;
                end
                RESP: begin
                    if_ready_r <= 1'b0;
                    d_ready_r  <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    if_ready_r <= 1'b0;
                    d_ready_r  <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: transaction-level reference model with per-cycle
// comparison, directed scenarios with literal expectations, then random traffic.
module tb_mem_access_ctrl;

    localparam int LIMIT = 3;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic        d_is_byte = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    always #5 clock = ~clock;

    mem_access_ctrl #(.STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_is_byte(d_is_byte), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    // Shared memory: 64 words, combinational read, write on the clock edge.
    logic [31:0] mem [0:63];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_val = 32'h0;
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clock) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        else if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model state (transaction level: who is served, when, with what).
    logic [31:0] shadow [0:63];
    int          cyc = 0;
    int          ready_cyc = -1;
    int          free_cyc = 0;
    int          starve_m = 0;
    bit          ready_is_d = 1'b0;
    bit          chk_store = 1'b0;
    int          store_idx = 0;
    bit          wr_pend = 1'b0;
    int          wr_cyc = 0;
    int          wr_idx = 0;
    logic [31:0] wr_val;
    logic [31:0] exp_if_rdata = 32'h0;
    logic [31:0] exp_d_rdata = 32'h0;
    bit          dgo, fgo;
    int          lat_m, lane_m, idx_m;
    logic [31:0] w_m;
    logic [7:0]  b_m;

    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            if (pl_en) shadow[pl_idx] = pl_val;
            if (!reset_n) begin
                check("rst_if_ready", {31'd0, if_ready}, 32'd0);
                check("rst_d_ready", {31'd0, d_ready}, 32'd0);
                check("rst_if_rdata", if_rdata, 32'd0);
                check("rst_d_rdata", d_rdata, 32'd0);
                check("rst_mem_we", {31'd0, mem_we}, 32'd0);
                ready_cyc = -1; free_cyc = cyc + 1; starve_m = 0; wr_pend = 1'b0;
                exp_if_rdata = 32'h0; exp_d_rdata = 32'h0; chk_store = 1'b0;
            end else begin
                check("if_ready", {31'd0, if_ready}, {31'd0, (cyc == ready_cyc) && !ready_is_d});
                check("d_ready", {31'd0, d_ready}, {31'd0, (cyc == ready_cyc) && ready_is_d});
                check("if_rdata", if_rdata, exp_if_rdata);
                check("d_rdata", d_rdata, exp_d_rdata);
                if (cyc == ready_cyc && chk_store) check("mem_after_store", mem[store_idx], shadow[store_idx]);
                if (wr_pend && cyc == wr_cyc) begin
                    shadow[wr_idx] = wr_val;
                    wr_pend = 1'b0;
                end
                if (cyc >= free_cyc) begin
                    dgo = d_req && !(if_req && starve_m == LIMIT);
                    fgo = if_req && !dgo;
                    if (dgo) begin
                        starve_m = if_req ? starve_m + 1 : 0;
                        idx_m = int'(d_addr[7:2]);
                        lane_m = int'(d_addr[1:0]);
                        w_m = shadow[idx_m];
                        store_idx = idx_m;
                        if (!d_we) begin
                            b_m = 8'(w_m >> (8 * lane_m));
                            exp_d_rdata = d_is_byte ? 32'($signed(b_m)) : w_m;
                            lat_m = 1; chk_store = 1'b0;
                        end else if (!d_is_byte) begin
                            shadow[idx_m] = d_wdata;
                            lat_m = 1; chk_store = 1'b1;
                        end else begin
                            wr_val = (w_m & ~(32'hFF << (8 * lane_m))) | ((d_wdata & 32'hFF) << (8 * lane_m));
                            wr_pend = 1'b1; wr_cyc = cyc + 1; wr_idx = idx_m;
                            lat_m = 2; chk_store = 1'b1;
                        end
                        ready_cyc = cyc + lat_m; ready_is_d = 1'b1; free_cyc = cyc + lat_m + 1;
                    end else if (fgo) begin
                        starve_m = 0;
                        exp_if_rdata = shadow[if_addr[7:2]];
                        ready_cyc = cyc + 1; ready_is_d = 1'b0; free_cyc = cyc + 2; chk_store = 1'b0;
                    end else begin
                        starve_m = 0;
                    end
                end
            end
        end
    end

    task automatic preload(input int idx, input logic [31:0] val);
        @(posedge clock); #1;
        pl_en = 1'b1; pl_idx = 6'(idx); pl_val = val;
        @(posedge clock); #1;
        pl_en = 1'b0;
    endtask

    task automatic access(input bit fetch, input bit we, input bit isb,
                          input logic [31:0] addr, input logic [31:0] wd, output int lat);
        @(posedge clock); #1;
        if (fetch) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            d_req = 1'b1; d_we = we; d_is_byte = isb; d_addr = addr; d_wdata = wd;
        end
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (fetch ? if_ready : d_ready) begin
                lat = k;
                break;
            end
        end
        @(posedge clock); #1;
        if_req = 1'b0; d_req = 1'b0;
    endtask

    int  lat, nd, dn, fn, d_total, f_total;
    bit  got, fetch_first, sd, sf, seen_rdy;

    initial begin
        for (int i = 0; i < 64; i++) preload(i, $urandom);
        preload(32'h40 >> 2, 32'h1122_3344);
        preload(32'h80 >> 2, 32'h0000_00F0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        access(1'b0, 1'b0, 1'b0, 32'h40, 32'h0, lat);
        check("word_load_lat", 32'(lat), 32'd2);
        check("word_load_data", d_rdata, 32'h1122_3344);
        access(1'b0, 1'b0, 1'b1, 32'h43, 32'h0, lat);
        check("byte_load_43", d_rdata, 32'h0000_0011);
        access(1'b0, 1'b0, 1'b1, 32'h40, 32'h0, lat);
        check("byte_load_40", d_rdata, 32'h0000_0044);
        access(1'b0, 1'b0, 1'b1, 32'h80, 32'h0, lat);
        check("byte_load_sext", d_rdata, 32'hFFFF_FFF0);
        check("byte_load_lat", 32'(lat), 32'd2);
        access(1'b0, 1'b1, 1'b1, 32'h41, 32'hABCD_EFAA, lat);
        check("byte_store_lat", 32'(lat), 32'd3);
        check("byte_store_mem", mem[32'h40 >> 2], 32'h1122_AA44);
        access(1'b0, 1'b1, 1'b0, 32'h44, 32'hCAFE_F00D, lat);
        check("word_store_lat", 32'(lat), 32'd2);
        check("word_store_mem", mem[32'h44 >> 2], 32'hCAFE_F00D);
        access(1'b1, 1'b0, 1'b0, 32'h46, 32'h0, lat);
        check("fetch_lat", 32'(lat), 32'd2);
        check("fetch_data", if_rdata, 32'hCAFE_F00D);

        // Reset during the MERGE cycle of a byte store aborts it.
        preload(32'h40 >> 2, 32'h1122_3344);
        @(posedge clock); #1;
        d_req = 1'b1; d_we = 1'b1; d_is_byte = 1'b1; d_addr = 32'h41; d_wdata = 32'hABCD_EFAA;
        @(posedge clock); #2;
        reset_n = 1'b0;
        d_is_byte = 1'b0;
        #1;
        check("rst_forces_we", {31'd0, mem_we}, 32'd0);
        @(negedge clock);
        seen_rdy = d_ready;
        @(posedge clock); #1;
        d_req = 1'b0;
        @(negedge clock);
        seen_rdy = seen_rdy | d_ready;
        @(posedge clock); #1;
        reset_n = 1'b1;
        check("abort_no_ready", {31'd0, seen_rdy}, 32'd0);
        check("abort_mem", mem[32'h40 >> 2], 32'h1122_3344);
        check("abort_d_rdata", d_rdata, 32'h0);
        check("abort_if_rdata", if_rdata, 32'h0);
        access(1'b0, 1'b0, 1'b0, 32'h40, 32'h0, lat);
        check("post_reset_lat", 32'(lat), 32'd2);

        // Contention: fetch must win after LIMIT consecutive data grants.
        @(posedge clock); #1;
        if_req = 1'b1; if_addr = 32'h48;
        d_req = 1'b1; d_we = 1'b0; d_is_byte = 1'b0; d_addr = 32'h40;
        nd = 0; got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (if_ready) begin
                got = 1'b1;
                break;
            end
            if (d_ready) nd++;
        end
        @(posedge clock); #1;
        if_req = 1'b0; d_req = 1'b0;
        check("starve_fetch_seen", {31'd0, got}, 32'd1);
        check("starve_data_count", 32'(nd), 32'(LIMIT));

        // Simultaneous single requests: data first, each ready once.
        repeat (2) @(posedge clock);
        #1;
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_is_byte = 1'b1; d_addr = 32'h80;
        dn = 0; fn = 0; fetch_first = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            sd = d_ready; sf = if_ready;
            if (sf && dn == 0) fetch_first = 1'b1;
            dn += int'(sd); fn += int'(sf);
            @(posedge clock); #1;
            if (sd) d_req = 1'b0;
            if (sf) if_req = 1'b0;
        end
        check("simul_d_pulses", 32'(dn), 32'd1);
        check("simul_f_pulses", 32'(fn), 32'd1);
        check("simul_data_first", {31'd0, fetch_first}, 32'd0);

        // Random traffic checked cycle by cycle against the model.
        d_total = 0; f_total = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clock);
            sd = d_ready; sf = if_ready;
            d_total += int'(sd); f_total += int'(sf);
            @(posedge clock); #1;
            if (sd || !d_req) begin
                if ($urandom_range(0, 2) != 0) begin
                    d_req = 1'b1; d_we = 1'($urandom); d_is_byte = 1'($urandom);
                    d_addr = 32'($urandom_range(0, 255)); d_wdata = $urandom;
                end else begin
                    d_req = 1'b0;
                end
            end
            if (sf || !if_req) begin
                if ($urandom_range(0, 2) != 0) begin
                    if_req = 1'b1; if_addr = 32'($urandom_range(0, 255));
                end else begin
                    if_req = 1'b0;
                end
            end
        end
        check("random_d_served", {31'd0, d_total > 100}, 32'd1);
        check("random_f_served", {31'd0, f_total > 100}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: consecutive lost arbitration cycles after which fetch wins; legal 1..7.
REQ-002 SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port if_req, input, 1: instruction-fetch read request, held until if_ready.
REQ-005 SHALL have port if_addr, input, 32: fetch byte address; bits [1:0] ignored.
REQ-006 SHALL have port if_rdata, output, 32: registered fetch word.
REQ-007 SHALL have port if_ready, output, 1: one-cycle completion pulse for fetch.
REQ-008 SHALL have port d_req, input, 1: data request from the memory stage, held with its attributes until d_ready.
REQ-009 SHALL have port d_we, input, 1: 1 = store, 0 = load.
REQ-010 SHALL have port d_is_byte, input, 1: 1 = byte access, 0 = word access.
REQ-011 SHALL have port d_addr, input, 32: data byte address.
REQ-012 SHALL have port d_wdata, input, 32: store data; byte stores use bits [7:0] only.
REQ-013 SHALL have port d_rdata, output, 32: registered load result; byte loads sign-extended.
REQ-014 SHALL have port d_ready, output, 1: one-cycle completion pulse for data.
REQ-015 SHALL have ports mem_addr (output, 32), mem_wdata (output, 32), mem_we (output, 1), mem_rdata (input, 32): the shared memory, which has combinational read and a write on the clock edge.

Function
REQ-016 SHALL implement an FSM with states IDLE, MERGE and RESP; requests are sampled only in IDLE.
REQ-017 IDLE with no request: SHALL drive mem_we=0 and stay in IDLE.
REQ-018 Arbitration in IDLE: d_req SHALL win over if_req, unless starve_cnt==STARVE_LIMIT, in which case fetch SHALL win.
REQ-019 starve_cnt (3 bits) SHALL increment in each IDLE cycle where if_req=1 and data is granted.
REQ-020 starve_cnt SHALL clear when fetch is granted or when an IDLE cycle has if_req=0.
REQ-021 mem_addr SHALL be {granted_addr[31:2],2'b00}; byte lane = addr[1:0], where lane k is bits [8k+7:8k].
REQ-022 Fetch grant or any data load: mem_we=0; at the edge, the result SHALL be registered into if_rdata or d_rdata, and the FSM SHALL go to RESP.
REQ-023 Byte load result SHALL be the selected lane, sign-extended to 32 bits.
REQ-024 Word store grant: mem_we=1, mem_wdata=d_wdata; next state RESP.
REQ-025 Byte store grant: mem_we=0 (read phase); at the edge, mem_rdata SHALL be captured into hold_word and the FSM SHALL go to MERGE.
REQ-026 MERGE: mem_we=1, mem_addr unchanged, mem_wdata = hold_word with the selected lane replaced by d_wdata[7:0] and other lanes preserved; next state RESP.
REQ-027 RESP: SHALL assert if_ready or d_ready (only the served requester) for exactly one cycle, with mem_we=0, and then go to IDLE.
REQ-028 Request inputs during RESP SHALL be ignored; requesters drop or replace the request at the RESP edge.
REQ-029 Latency SHALL be: load/fetch/word store = ready in cycle G+1; byte store = ready in cycle G+2 (G = grant cycle).
REQ-030 if_rdata and d_rdata SHALL hold their last value until overwritten.
REQ-031 Unmodified lanes of memory SHALL never change on a byte store.

Reset
REQ-032 On reset_n=0, the block SHALL immediately set state=IDLE, starve_cnt=0, if_ready=0, d_ready=0, if_rdata=0, d_rdata=0, hold_word=0, and force mem_we=0.
REQ-033 Reset during MERGE or RESP SHALL abort the access: no memory write and no ready pulse.
REQ-034 After reset_n rises, the first grant SHALL occur on the first rising edge with a request.

Verification
REQ-035 Word load: mem[0x40]=0x11223344, d_req load word addr 0x40 -> d_ready at G+1, d_rdata=0x11223344.
REQ-036 Byte load: same word, addr 0x43 and addr 0x40 -> d_rdata=0x00000011, then 0x00000044; mem[0x80]=0x000000F0, addr 0x80 -> 0xFFFFFFF0.
REQ-037 Byte store: mem[0x40]=0x11223344, d_wdata=0xABCDEFAA to addr 0x41 -> read at G, write at G+1, d_ready at G+2, mem[0x40]=0x1122AA44.
REQ-038 Contention: if_req and d_req both held continuously with back-to-back data requests -> with STARVE_LIMIT=3, after 3 data grants fetch is granted; counter cleared.
REQ-039 Simultaneous single requests: both raised in one cycle -> data served first, fetch granted at the next IDLE, each ready pulses only once.
REQ-040 Reset in MERGE: reset_n low during the MERGE cycle of the REQ-037 store -> mem[0x40] stays 0x11223344, no d_ready, outputs return to their reset values.
